// File: rtl/backprop_scheduler.sv
// Backpropagation sequencer: walks (layer,row) pairs from the output layer down to 0,
// launching the diff_backprop_reg stage per pair. Optional WAIT watchdog: BACKPROP_SCHED_TIMEOUT_EN.
module backprop_scheduler #(
  parameter int unsigned layer_count     = 3,
  parameter int unsigned row_count_max   = 3,
  parameter int unsigned dense_type_size = 4,
  parameter int unsigned timeout_cycles  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       train,
  output logic [31:0]                cfg_layer_index,
  input  logic [31:0]                cfg_row_count,
  input  logic [dense_type_size-1:0] cfg_dense_type,
  input  logic                       stage_done,
  output logic                       stage_valid,
  output logic [31:0]                w_layer_index,
  output logic [31:0]                w_row_index,
  output logic                       backprop_cost,
  output logic [31:0]                dense_type,
  output logic                       is_update,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned IdxW = 32;
  localparam logic [IdxW-1:0] LastLayer = IdxW'(layer_count - 1);
  localparam logic [IdxW-1:0] RowMax    = IdxW'(row_count_max);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] layer_q, layer_d;
  logic [IdxW-1:0] row_q, row_d;
  logic [IdxW-1:0] rows_q, rows_d;
  logic [IdxW-1:0] cfg_idx_q, cfg_idx_d;
  logic [IdxW-1:0] w_layer_q, w_layer_d;
  logic [IdxW-1:0] w_row_q, w_row_d;
  logic [IdxW-1:0] dense_q, dense_d;
  logic            train_q, train_d;
  logic            valid_q, valid_d;
  logic            cost_q, cost_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            stage_done_q, stage_done_d;

  logic [IdxW-1:0] rows_clamp_c;
  logic            done_edge_c;
  logic            next_layer_c;

`ifdef BACKPROP_SCHED_TIMEOUT_EN
  localparam int unsigned       TmrW     = $clog2(timeout_cycles + 1);
  localparam logic [TmrW-1:0]   TmrLimit = TmrW'(timeout_cycles - 1);
  logic [TmrW-1:0] timer_q, timer_d;
  logic            error_q, error_d;
`else
  logic [IdxW-1:0] unused_timeout;
  assign unused_timeout = IdxW'(timeout_cycles);
`endif

  assign rows_clamp_c = (cfg_row_count > RowMax) ? RowMax : cfg_row_count;
  // stage_done_q tracks every cycle, so an edge seen during ISSUE is already stale in WAIT
  assign done_edge_c  = stage_done & ~stage_done_q;

  // next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    row_d        = row_q;
    rows_d       = rows_q;
    cfg_idx_d    = cfg_idx_q;
    w_layer_d    = w_layer_q;
    w_row_d      = w_row_q;
    dense_d      = dense_q;
    train_d      = train_q;
    cost_d       = cost_q;
    stage_done_d = stage_done;
    next_layer_c = 1'b0;
`ifdef BACKPROP_SCHED_TIMEOUT_EN
    timer_d      = timer_q;
    error_d      = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          layer_d = LastLayer;
          row_d   = '0;
          train_d = train;
`ifdef BACKPROP_SCHED_TIMEOUT_EN
          error_d = 1'b0;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rows_d  = rows_clamp_c;
        dense_d = IdxW'(cfg_dense_type);
        if (rows_clamp_c == '0) begin
          next_layer_c = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_edge_c) begin
          if (row_q + IdxW'(1) < rows_q) begin
            row_d   = row_q + IdxW'(1);
            state_d = S_ISSUE;
          end else begin
            next_layer_c = 1'b1;
          end
        end
`ifdef BACKPROP_SCHED_TIMEOUT_EN
        else if (timer_q == TmrLimit) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
`endif
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // shared by an empty layer in LOAD and the last row completing in WAIT
    if (next_layer_c) begin
      if (layer_q == '0) begin
        state_d = S_FIN;
      end else begin
        layer_d = layer_q - IdxW'(1);
        row_d   = '0;
        state_d = S_LOAD;
      end
    end

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    valid_d = (state_d == S_ISSUE);
    if (state_d == S_LOAD) begin
      cfg_idx_d = layer_d;
    end
    if (state_d == S_ISSUE) begin
      w_layer_d = layer_d;
      w_row_d   = row_d;
      cost_d    = (layer_d == LastLayer);
    end

`ifdef BACKPROP_SCHED_TIMEOUT_EN
    if (state_q == S_ISSUE) begin
      timer_d = '0;
    end else if (state_q == S_WAIT) begin
      timer_d = timer_q + TmrW'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      row_q        <= '0;
      rows_q       <= '0;
      cfg_idx_q    <= '0;
      w_layer_q    <= '0;
      w_row_q      <= '0;
      dense_q      <= '0;
      train_q      <= 1'b0;
      valid_q      <= 1'b0;
      cost_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      stage_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      row_q        <= row_d;
      rows_q       <= rows_d;
      cfg_idx_q    <= cfg_idx_d;
      w_layer_q    <= w_layer_d;
      w_row_q      <= w_row_d;
      dense_q      <= dense_d;
      train_q      <= train_d;
      valid_q      <= valid_d;
      cost_q       <= cost_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      stage_done_q <= stage_done_d;
    end
  end

`ifdef BACKPROP_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign cfg_layer_index = cfg_idx_q;
  assign stage_valid     = valid_q;
  assign w_layer_index   = w_layer_q;
  assign w_row_index     = w_row_q;
  assign backprop_cost   = cost_q;
  assign dense_type      = dense_q;
  assign is_update       = train_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
